// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream domain resets one at a time, with retry and failure handling.
module pll_rst_seq #(
  parameter int NUM_DOMAINS  = 6,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRY    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic [3:0]             retry_cnt,
  output logic                   err
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int CNT_MAX = max4(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT, NUM_DOMAINS * STAGGER);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FAIL_W  = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]  RELEASE_LAST = CNT_W'((NUM_DOMAINS - 1) * STAGGER);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_RETRY);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  typedef enum logic [2:0] {
    PULSE, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [FAIL_W-1:0]  fail_cnt, fail_n, fail_inc;
  logic [3:0]         retry_n;
  logic               timeout, lost;
  logic               pll_rst_n, all_ready_n, err_n;
  logic [NUM_DOMAINS-1:0] domain_rst_n;

  // Lock synchronizer: sync_p0 may go metastable, lock_s is the only lock used below
  logic sync_p0, lock_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_p0 <= pll_locked;
      lock_s  <= sync_p0;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    retry_n  = retry_cnt;
    fail_n   = fail_cnt;
    fail_inc = fail_cnt + FAIL_W'(1);
    timeout  = 1'b0;
    lost     = 1'b0;

    case (state)
      PULSE:     if (cnt == PULSE_LAST) state_n = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                    state_n = STABLE;
        else if (cnt == TIMEOUT_LAST)  timeout = 1'b1;
      end
      STABLE: begin
        if (!lock_s)                   state_n = WAIT_LOCK;
        else if (cnt == STABLE_LAST)   state_n = RELEASE;
      end
      RELEASE: begin
        if (!lock_s)                   lost    = 1'b1;
        else if (cnt == RELEASE_LAST)  state_n = RUN;
      end
      RUN:       if (!lock_s) lost = 1'b1;
      FAIL:      state_n = FAIL;
      default:   state_n = PULSE;
    endcase

    // Lock loss after release counts as a retry but not as a consecutive failure
    if (lost) begin
      state_n = PULSE;
      retry_n = sat_inc(retry_cnt);
    end
    if (timeout) begin
      retry_n = sat_inc(retry_cnt);
      fail_n  = fail_inc;
      state_n = (fail_inc >= FAIL_LIMIT) ? FAIL : PULSE;
    end
    if (state_n == RUN && state != RUN) fail_n = '0;

    if (state_n != state)                   cnt_n = '0;
    else if (state == RUN || state == FAIL) cnt_n = cnt;

    // Outputs are derived from the next state so the registers line up with it
    pll_rst_n    = (state_n == PULSE) || (state_n == FAIL);
    all_ready_n  = (state_n == RUN);
    err_n        = (state_n == FAIL);
    domain_rst_n = '1;
    if (state_n == RUN) domain_rst_n = '0;
    if (state_n == RELEASE) begin
      for (int k = 0; k < NUM_DOMAINS; k++) begin
        if (cnt_n >= CNT_W'(k * STAGGER)) domain_rst_n[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PULSE;
      cnt        <= '0;
      fail_cnt   <= '0;
      retry_cnt  <= 4'd0;
      pll_rst    <= 1'b1;
      domain_rst <= '1;
      all_ready  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      fail_cnt   <= fail_n;
      retry_cnt  <= retry_n;
      pll_rst    <= pll_rst_n;
      domain_rst <= domain_rst_n;
      all_ready  <= all_ready_n;
      err        <= err_n;
    end
  end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  NUM_DOMAINS, 6, number of downstream clock domains (one per PLL output)
  RST_PULSE, 16, pll_rst pulse width in clk cycles
  LOCK_STABLE, 1024, consecutive synchronized-lock cycles required before release
  LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before retry
  STAGGER, 8, cycles between successive domain reset releases
  MAX_RETRY, 4, consecutive lock failures before FAIL
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk, in, 1, PLL reference clock; the only clock
  reset, in, 1, synchronous active-high reset
  pll_locked, in, 1, PLL locked, asynchronous to clk
  pll_rst, out, 1, PLL reset, active high
  domain_rst, out, NUM_DOMAINS, per-domain reset, active high; consumer resynchronizes
  all_ready, out, 1, all domains released, PLL running
  retry_cnt, out, 4, total retries since reset, saturating at 15
  err, out, 1, sticky failure flag
REQ-003 The block SHALL have exactly one clock, clk, and reset SHALL be synchronous and active-high.

Function
REQ-004 pll_locked SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-005 FSM states: PULSE, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL; one shared cycle counter, reloaded to 0 on every state entry.
REQ-006 PULSE: pll_rst=1, all domain_rst=1; after RST_PULSE cycles -> WAIT_LOCK.
REQ-007 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT with lock_s=0 -> retry (REQ-011).
REQ-008 STABLE: counts consecutive lock_s=1 cycles; lock_s=0 -> WAIT_LOCK with timeout restarted; LOCK_STABLE reached -> RELEASE.
REQ-009 RELEASE: domain_rst[0] deasserts on the first RELEASE cycle; domain_rst[k] deasserts exactly k*STAGGER cycles after domain_rst[0]; once released, a bit stays low until lock loss or reset. One cycle after domain_rst[NUM_DOMAINS-1] deasserts -> RUN, all_ready=1.
REQ-010 Lock loss: lock_s=0 in RELEASE or RUN -> next cycle all domain_rst=1, all_ready=0, state PULSE, retry_cnt+1 (saturating); the consecutive-failure counter is not incremented.
REQ-011 Timeout retry: -> PULSE, retry_cnt+1 (saturating), internal consecutive-failure counter +1; counter reaching MAX_RETRY -> FAIL instead of PULSE.
REQ-012 Consecutive-failure counter SHALL clear on entry to RUN.
REQ-013 FAIL: pll_rst=1, all domain_rst=1, all_ready=0, err=1; held until reset.
REQ-014 All outputs SHALL be registered; no combinational path from pll_locked to any output.
REQ-015 Counter width SHALL cover max(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT, NUM_DOMAINS*STAGGER) without wrap.

Reset
REQ-016 While reset=1, the next edge SHALL load: state=PULSE, counter=0, pll_rst=1, domain_rst=all ones, all_ready=0, retry_cnt=0, err=0, failure counter=0, synchronizer flops=0.
REQ-017 Reset asserted in any state, including FAIL and mid-RELEASE, SHALL take effect on the next edge with no partial release.
REQ-018 After reset deasserts, pll_rst SHALL remain 1 for exactly RST_PULSE cycles.

Verification (bench params: RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, STAGGER=2, MAX_RETRY=3, NUM_DOMAINS=6)
REQ-019 pll_locked tied 1 -> pll_rst high 4 cycles after reset; domain_rst[0] falls 8+sync cycles after pll_rst falls; domain_rst[k] falls 2k cycles after bit 0; all_ready=1 one cycle after bit 5; retry_cnt=0.
REQ-020 pll_locked glitches low 1 cycle midway through STABLE -> STABLE restarts; release delayed by the lost count; no retry; retry_cnt=0.
REQ-021 pll_locked drops in RUN -> next cycle after lock_s falls, all domain_rst=6'h3F, all_ready=0, pll_rst=1 for 4 cycles; retry_cnt=1; a clean re-lock releases again.
REQ-022 pll_locked held 0 -> three 32-cycle timeouts, retry_cnt=3, then FAIL: err=1, pll_rst=1; raising pll_locked afterwards changes nothing.
REQ-023 reset pulsed mid-RELEASE (after 3 domains released) -> next edge all domain_rst=1, retry_cnt=0, err=0, full sequence restarts.
REQ-024 18 lock-loss events in RUN -> retry_cnt saturates at 15, err stays 0.
